// File: rtl/snk_ioctl_loader_pkg.sv
// Shared types and constants for the ioctl loader: ROM region map, download
// indices, FIFO entry layout and loader state encoding.
package snk_loader_pkg;

  localparam int NUM_REGIONS = 8;
  localparam int REGION_W    = 3;

  localparam logic [7:0] IDX_ROM  = 8'd0;
  localparam logic [7:0] IDX_GAME = 8'd1;
  localparam logic [7:0] IDX_DSW  = 8'd254;

  typedef struct packed {
    logic [24:0] base;
    logic [22:0] size;
  } region_t;

  typedef struct packed {
    logic [REGION_W-1:0] region;
    logic [21:0]         addr;
    logic [7:0]          data;
  } rom_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Regions are contiguous and non-overlapping; anything at or above 0x380000 is unmapped.
  localparam region_t REGION_TABLE [NUM_REGIONS] = '{
    '{base: 25'h000_0000, size: 23'h08_0000},
    '{base: 25'h008_0000, size: 23'h02_0000},
    '{base: 25'h00A_0000, size: 23'h01_0000},
    '{base: 25'h00B_0000, size: 23'h01_0000},
    '{base: 25'h00C_0000, size: 23'h10_0000},
    '{base: 25'h01C_0000, size: 23'h04_0000},
    '{base: 25'h020_0000, size: 23'h10_0000},
    '{base: 25'h030_0000, size: 23'h08_0000}
  };

  function automatic logic region_hit(input logic [24:0] addr, input region_t r);
    logic [25:0] lo;
    logic [25:0] hi;
    lo = {1'b0, r.base};
    hi = {1'b0, r.base} + {3'b000, r.size};
    return ({1'b0, addr} >= lo) && ({1'b0, addr} < hi);
  endfunction

endpackage

// File: rtl/snk_ioctl_loader_if.sv
// hps_io download stream plus the ROM write request channel toward the Z80 core.
interface snk_ioctl_loader_if;
  import snk_loader_pkg::*;

  logic                ioctl_download;
  logic [7:0]          ioctl_index;
  logic                ioctl_wr;
  logic [24:0]         ioctl_addr;
  logic [7:0]          ioctl_dout;
  logic                ioctl_wait;
  logic                rom_wr;
  logic                rom_ready;
  logic [REGION_W-1:0] rom_region;
  logic [21:0]         rom_addr;
  logic [7:0]          rom_data;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, rom_ready,
    input  ioctl_wait, rom_wr, rom_region, rom_addr, rom_data
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, rom_ready,
    output ioctl_wait, rom_wr, rom_region, rom_addr, rom_data
  );
endinterface

// File: rtl/snk_ioctl_loader_chk.sv
// Simulation checks for the loader: the write FIFO must never be pushed while full.
module snk_loader_chk (
  input logic i_clk,
  input logic RESETn,
  input logic push,
  input logic full
);
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!RESETn) !(push && full));
endmodule

// File: rtl/snk_ioctl_loader_fifo.sv
// Small synchronous FIFO of ROM write requests with an occupancy count.
module snk_loader_fifo
  import snk_loader_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          RESETn,
  input  logic          push,
  input  logic          pop,
  input  rom_req_t      din,
  output rom_req_t      dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int AW = CW - 1;

  rom_req_t      mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge RESETn) begin
    if (!RESETn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/snk_ioctl_loader.sv
// Routes the hps_io download stream: ROM bytes to region write requests via a
// FIFO, game-select and DIP bytes to registers, plus load status/checksum.
module snk_ioctl_loader
  import snk_loader_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int HIGH_WATER = 2
) (
  input  logic                i_clk,
  input  logic                RESETn,
  snk_ioctl_loader_if.slave   bus,
  output logic [7:0]          game,
  output logic [63:0]         dsw,
  output logic                rom_loaded,
  output logic [24:0]         byte_count,
  output logic [15:0]         checksum
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t              state_r;
  logic [24:0]         byte_count_r;
  logic [15:0]         checksum_r;
  logic                rom_loaded_r;
  logic                overflow_r;
  logic [7:0]          game_r;
  logic [63:0]         dsw_r;
  logic                wait_r;

  logic [NUM_REGIONS-1:0] match_s;
  logic                hit_s;
  logic [REGION_W-1:0] region_s;
  logic [21:0]         offset_s;
  rom_req_t            req_s;
  rom_req_t            head_s;
  logic                rom_byte_s;
  logic                push_s;
  logic                pop_s;
  logic                push_full_s;
  logic                game_wr_s;
  logic                dsw_wr_s;
  logic                start_s;
  logic [24:0]         cnt_base_s;
  logic [15:0]         sum_base_s;
  logic [CW-1:0]       count_s;
  logic [CW-1:0]       next_cnt_s;
  logic                full_s;
  logic                empty_s;

  // Region lookup: at most one region matches because the table does not overlap.
  always_comb begin
    match_s  = '0;
    region_s = '0;
    offset_s = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      match_s[i] = region_hit(bus.ioctl_addr, REGION_TABLE[i]);
      region_s   = match_s[i] ? REGION_W'(i) : region_s;
      offset_s   = match_s[i] ? 22'(bus.ioctl_addr - REGION_TABLE[i].base) : offset_s;
    end
  end

  assign hit_s = |match_s;

  // Strobe qualification and next-cycle bookkeeping values.
  always_comb begin
    rom_byte_s  = bus.ioctl_wr & (bus.ioctl_index == IDX_ROM);
    push_s      = rom_byte_s & hit_s;
    pop_s       = ~empty_s & bus.rom_ready;
    push_full_s = push_s & full_s;
    game_wr_s   = bus.ioctl_wr & (bus.ioctl_index == IDX_GAME) & (bus.ioctl_addr == 25'd0);
    dsw_wr_s    = bus.ioctl_wr & (bus.ioctl_index == IDX_DSW) & (bus.ioctl_addr[24:3] == 22'd0);
    start_s     = bus.ioctl_download & (bus.ioctl_index == IDX_ROM) & (state_r != LOAD);
    cnt_base_s  = start_s ? 25'd0 : byte_count_r;
    sum_base_s  = start_s ? 16'd0 : checksum_r;
    next_cnt_s  = count_s + CW'(push_s & ~full_s) - CW'(pop_s);
    req_s       = '{region: region_s, addr: offset_s, data: bus.ioctl_dout};
  end

  snk_loader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .i_clk  (i_clk),
    .RESETn (RESETn),
    .push   (push_s),
    .pop    (pop_s),
    .din    (req_s),
    .dout   (head_s),
    .count  (count_s),
    .full   (full_s),
    .empty  (empty_s)
  );

  snk_loader_chk u_chk (
    .i_clk  (i_clk),
    .RESETn (RESETn),
    .push   (push_s),
    .full   (full_s)
  );

  // Loader FSM together with every registered output it owns.
  always_ff @(posedge i_clk or negedge RESETn) begin
    if (!RESETn) begin
      state_r      <= IDLE;
      byte_count_r <= 25'd0;
      checksum_r   <= 16'd0;
      rom_loaded_r <= 1'b0;
      overflow_r   <= 1'b0;
      game_r       <= 8'h00;
      dsw_r        <= {64{1'b1}};
      wait_r       <= 1'b0;
    end else begin
      wait_r <= (next_cnt_s >= CW'(HIGH_WATER));
      if (game_wr_s) begin
        game_r <= bus.ioctl_dout;
      end
      if (dsw_wr_s) begin
        dsw_r[{bus.ioctl_addr[2:0], 3'b000} +: 8] <= bus.ioctl_dout;
      end
      // Unmapped ROM bytes still count toward byte_count and checksum.
      if (rom_byte_s) begin
        byte_count_r <= cnt_base_s + 25'd1;
        checksum_r   <= sum_base_s + {8'h00, bus.ioctl_dout};
      end else if (start_s) begin
        byte_count_r <= 25'd0;
        checksum_r   <= 16'd0;
      end
      if (start_s) begin
        overflow_r <= push_full_s;
      end else if (push_full_s) begin
        overflow_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (start_s) begin
            state_r      <= LOAD;
            rom_loaded_r <= 1'b0;
          end
        end
        LOAD: begin
          if (!bus.ioctl_download) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          if (start_s) begin
            state_r      <= LOAD;
            rom_loaded_r <= 1'b0;
          end else if (empty_s) begin
            state_r      <= DONE;
            rom_loaded_r <= ~overflow_r;
          end
        end
        DONE: begin
          if (start_s) begin
            state_r      <= LOAD;
            rom_loaded_r <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.ioctl_wait = wait_r;
  assign bus.rom_wr     = ~empty_s;
  assign bus.rom_region = head_s.region;
  assign bus.rom_addr   = head_s.addr;
  assign bus.rom_data   = head_s.data;
  assign game           = game_r;
  assign dsw            = dsw_r;
  assign rom_loaded     = rom_loaded_r;
  assign byte_count     = byte_count_r;
  assign checksum       = checksum_r;
endmodule

// File: tb/tb_snk_ioctl_loader.sv
// Directed self-checking bench for snk_ioctl_loader.
module tb_snk_ioctl_loader;
  import snk_loader_pkg::*;

  logic        i_clk;
  logic        RESETn;
  logic [7:0]  game;
  logic [63:0] dsw;
  logic        rom_loaded;
  logic [24:0] byte_count;
  logic [15:0] checksum;
  int          n_cmp;
  int          n_err;
  logic [32:0] beats [$];

  snk_ioctl_loader_if bus ();

  snk_ioctl_loader dut (
    .i_clk      (i_clk),
    .RESETn     (RESETn),
    .bus        (bus),
    .game       (game),
    .dsw        (dsw),
    .rom_loaded (rom_loaded),
    .byte_count (byte_count),
    .checksum   (checksum)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Record every accepted ROM request, sampled mid-cycle before the popping edge.
  always @(negedge i_clk) begin
    if (bus.rom_wr === 1'b1 && bus.rom_ready === 1'b1)
      beats.push_back({bus.rom_region, bus.rom_addr, bus.rom_data});
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    tick();
    bus.ioctl_wr   = 1'b0;
  endtask

  initial begin
    int b0;
    logic [32:0] exp_beat;
    n_cmp = 0;
    n_err = 0;
    RESETn             = 1'b0;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = 25'd0;
    bus.ioctl_dout     = 8'd0;
    bus.rom_ready      = 1'b1;
    tick();
    tick();
    chk("rst_rom_wr", 64'(bus.rom_wr), 64'd0);
    chk("rst_wait", 64'(bus.ioctl_wait), 64'd0);
    chk("rst_loaded", 64'(rom_loaded), 64'd0);
    chk("rst_count", 64'(byte_count), 64'd0);
    chk("rst_sum", 64'(checksum), 64'd0);
    chk("rst_game", 64'(game), 64'd0);
    chk("rst_dsw", dsw, 64'hFFFF_FFFF_FFFF_FFFF);
    RESETn = 1'b1;
    tick();

    // T1: 16 bytes into region 0 with the sink always ready
    b0 = beats.size();
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = 8'd0;
    tick();
    chk("t1_state", 64'(dut.state_r), 64'(LOAD));
    for (int i = 0; i < 16; i++) begin
      wr_byte(25'(i), 8'(i + 1));
      chk("t1_rom_wr", 64'(bus.rom_wr), 64'd1);
      chk("t1_head_addr", 64'(bus.rom_addr), 64'(i));
      chk("t1_head_data", 64'(bus.rom_data), 64'(i + 1));
      chk("t1_wait", 64'(bus.ioctl_wait), 64'd0);
    end
    bus.ioctl_download = 1'b0;
    tick();
    chk("t1_empty", 64'(bus.rom_wr), 64'd0);
    chk("t1_loaded_early", 64'(rom_loaded), 64'd0);
    tick();
    chk("t1_loaded", 64'(rom_loaded), 64'd1);
    chk("t1_count", 64'(byte_count), 64'd16);
    chk("t1_sum", 64'(checksum), 64'h0088);
    chk("t1_nbeats", 64'(beats.size() - b0), 64'd16);
    for (int i = 0; i < 16; i++) begin
      exp_beat = {3'd0, 22'(i), 8'(i + 1)};
      chk("t1_beat", 64'(beats[b0 + i]), 64'(exp_beat));
    end

    // T2: second download with back-pressure; counters restart on entry
    b0 = beats.size();
    bus.rom_ready      = 1'b0;
    bus.ioctl_download = 1'b1;
    tick();
    chk("t2_loaded_drop", 64'(rom_loaded), 64'd0);
    chk("t2_sum_clr", 64'(checksum), 64'd0);
    chk("t2_count_clr", 64'(byte_count), 64'd0);
    wr_byte(25'h100, 8'h20);
    chk("t2_latency", 64'(bus.rom_wr), 64'd1);
    chk("t2_wait_occ1", 64'(bus.ioctl_wait), 64'd0);
    wr_byte(25'h101, 8'h21);
    chk("t2_wait_occ2", 64'(bus.ioctl_wait), 64'd1);
    wr_byte(25'h102, 8'h22);
    chk("t2_wait_occ3", 64'(bus.ioctl_wait), 64'd1);
    tick();
    tick();
    chk("t2_wait_hold", 64'(bus.ioctl_wait), 64'd1);
    chk("t2_head_hold", 64'(bus.rom_addr), 64'h100);
    chk("t2_count3", 64'(byte_count), 64'd3);
    bus.rom_ready = 1'b1;
    tick();
    chk("t2_wait_occ2b", 64'(bus.ioctl_wait), 64'd1);
    chk("t2_head_next", 64'(bus.rom_addr), 64'h101);
    tick();
    chk("t2_wait_fall", 64'(bus.ioctl_wait), 64'd0);
    wr_byte(25'h103, 8'h23);
    wr_byte(25'h104, 8'h24);
    bus.ioctl_download = 1'b0;
    tick();
    tick();
    chk("t2_loaded", 64'(rom_loaded), 64'd1);
    chk("t2_count", 64'(byte_count), 64'd5);
    chk("t2_sum", 64'(checksum), 64'h00AA);
    chk("t2_nbeats", 64'(beats.size() - b0), 64'd5);
    for (int i = 0; i < 5; i++) begin
      exp_beat = {3'd0, 22'(32'h100 + i), 8'(32'h20 + i)};
      chk("t2_beat", 64'(beats[b0 + i]), 64'(exp_beat));
    end

    // T3: region decode, unmapped address and a region end boundary
    bus.rom_ready      = 1'b0;
    bus.ioctl_download = 1'b1;
    tick();
    wr_byte(25'h00B_0123, 8'h5A);
    chk("t3_rom_wr", 64'(bus.rom_wr), 64'd1);
    chk("t3_region", 64'(bus.rom_region), 64'd3);
    chk("t3_addr", 64'(bus.rom_addr), 64'h123);
    chk("t3_data", 64'(bus.rom_data), 64'h5A);
    bus.rom_ready = 1'b1;
    tick();
    wr_byte(25'h100_0000, 8'h11);
    chk("t3_miss_no_wr", 64'(bus.rom_wr), 64'd0);
    chk("t3_miss_count", 64'(byte_count), 64'd2);
    wr_byte(25'h00A_FFFF, 8'h01);
    chk("t3_edge_region", 64'(bus.rom_region), 64'd2);
    chk("t3_edge_addr", 64'(bus.rom_addr), 64'hFFFF);
    bus.ioctl_download = 1'b0;
    tick();
    tick();
    chk("t3_loaded", 64'(rom_loaded), 64'd1);
    chk("t3_count", 64'(byte_count), 64'd3);
    chk("t3_sum", 64'(checksum), 64'h006C);

    // T4: DIP and game-select downloads leave the ROM status alone
    bus.ioctl_index    = 8'd254;
    bus.ioctl_download = 1'b1;
    tick();
    wr_byte(25'd0, 8'hA5);
    chk("t4_dsw0", dsw, 64'hFFFF_FFFF_FFFF_FFA5);
    wr_byte(25'd1, 8'h3C);
    wr_byte(25'd8, 8'h00);
    chk("t4_dsw", dsw, 64'hFFFF_FFFF_FFFF_3CA5);
    bus.ioctl_download = 1'b0;
    tick();
    bus.ioctl_index    = 8'd1;
    bus.ioctl_download = 1'b1;
    tick();
    wr_byte(25'd0, 8'h02);
    chk("t4_game", 64'(game), 64'h02);
    wr_byte(25'd1, 8'h07);
    chk("t4_game_hold", 64'(game), 64'h02);
    bus.ioctl_download = 1'b0;
    tick();
    chk("t4_loaded", 64'(rom_loaded), 64'd1);
    chk("t4_count", 64'(byte_count), 64'd3);
    chk("t4_state", 64'(dut.state_r), 64'(DONE));

    // T5: asynchronous reset with three requests queued
    bus.rom_ready      = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_download = 1'b1;
    tick();
    wr_byte(25'd0, 8'h31);
    wr_byte(25'd1, 8'h32);
    wr_byte(25'd2, 8'h33);
    chk("t5_queued", 64'(bus.rom_wr), 64'd1);
    chk("t5_count3", 64'(byte_count), 64'd3);
    #2;
    RESETn = 1'b0;
    #1;
    chk("t5_rom_wr", 64'(bus.rom_wr), 64'd0);
    chk("t5_wait", 64'(bus.ioctl_wait), 64'd0);
    chk("t5_count", 64'(byte_count), 64'd0);
    chk("t5_sum", 64'(checksum), 64'd0);
    chk("t5_dsw", dsw, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t5_game", 64'(game), 64'd0);
    chk("t5_loaded", 64'(rom_loaded), 64'd0);
    chk("t5_state", 64'(dut.state_r), 64'(IDLE));
    bus.ioctl_download = 1'b0;
    tick();
    RESETn = 1'b1;
    tick();
    tick();
    chk("t5_post_rom_wr", 64'(bus.rom_wr), 64'd0);
    chk("t5_post_state", 64'(dut.state_r), 64'(IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
